// File: rtl/prores_sched_pkg.sv
// Shared definitions for the ProRes bitstream scheduler.
//   - sched_state_e : scheduler FSM states, in slice order
//   - cw_t / lvl_cw_t : codeword shapes at the default requester widths
//   - SB_W : width of the set_bit value / size buses
package prores_sched_pkg;

  localparam int SB_W      = 64;
  localparam int CW_VAL_W  = 32;
  localparam int CW_SIZE_W = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DC     = 3'd1,
    AC_RUN = 3'd2,
    AC_LVL = 3'd3,
    FLUSH  = 3'd4,
    DONE   = 3'd5
  } sched_state_e;

  typedef struct packed {
    logic [CW_VAL_W-1:0]  val;
    logic [CW_SIZE_W-1:0] size;
  } cw_t;

  typedef struct packed {
    logic [CW_VAL_W-1:0]  val;
    logic [CW_SIZE_W-1:0] size;
    logic                 last;
  } lvl_cw_t;

endpackage

// File: rtl/bitstream_scheduler_if.sv
// Request bundle from the three entropy coders into the scheduler.
//   dc_*  : DC codeword channel
//   run_* : AC run codeword channel
//   lvl_* : AC level codeword channel, lvl_last marks the slice's final level
// master = producers, slave = scheduler (drives the ready lines).
interface bitstream_scheduler_if #(
  parameter int VAL_W  = 32,
  parameter int SIZE_W = 6
);
  logic              dc_valid;
  logic              dc_ready;
  logic [VAL_W-1:0]  dc_val;
  logic [SIZE_W-1:0] dc_size;

  logic              run_valid;
  logic              run_ready;
  logic [VAL_W-1:0]  run_val;
  logic [SIZE_W-1:0] run_size;

  logic              lvl_valid;
  logic              lvl_ready;
  logic [VAL_W-1:0]  lvl_val;
  logic [SIZE_W-1:0] lvl_size;
  logic              lvl_last;

  modport master (
    output dc_valid, dc_val, dc_size,
    output run_valid, run_val, run_size,
    output lvl_valid, lvl_val, lvl_size, lvl_last,
    input  dc_ready, run_ready, lvl_ready
  );

  modport slave (
    input  dc_valid, dc_val, dc_size,
    input  run_valid, run_val, run_size,
    input  lvl_valid, lvl_val, lvl_size, lvl_last,
    output dc_ready, run_ready, lvl_ready
  );
endinterface

// File: rtl/codeword_fifo.sv
// Small synchronous FIFO holding one requester's queued codewords.
//   clk_i, rst_ni   : clock, asynchronous active-low reset (empties the FIFO)
//   push_i, wdata_i : write request; ignored while full
//   pop_i           : read request; ignored while empty
//   rdata_o         : head entry, addressed by the registered read pointer
//   full_o, empty_o : occupancy flags
module codeword_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en_s;
  logic             pop_en_s;

  // Pointers carry one wrap bit: equal = empty, only the wrap bit differs = full.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Full is taken from registered pointers, so a same-cycle pop never frees a slot.
  assign push_en_s = push_i && !full_o;
  assign pop_en_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_en_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/bitstream_scheduler.sv
// Serialises DC, AC run and AC level codewords onto the shared set_bit port
// in slice order: block_num DC codewords, run/level pairs until a level
// marked last, then one flush.
//   clock, reset_n      : clock, asynchronous active-low reset
//   slice_start         : pulse that starts a slice; block_num sampled with it
//   req                 : three codeword request channels (valid/ready)
//   sb_enable/val/size  : registered set_bit write, zero-extended to 64 bits
//   sb_flush            : registered set_bit flush request
//   busy                : a slice schedule is in progress
//   slice_done          : one-cycle pulse when the schedule completes
//   protocol_error      : one-cycle pulse when slice_start arrives while busy
module bitstream_scheduler
  import prores_sched_pkg::*;
#(
  parameter int VAL_W      = 32,
  parameter int SIZE_W     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int BLK_W      = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 slice_start,
  input  logic [BLK_W-1:0]     block_num,
  bitstream_scheduler_if.slave req,
  output logic                 sb_enable,
  output logic [SB_W-1:0]      sb_val,
  output logic [SB_W-1:0]      sb_size_of_bit,
  output logic                 sb_flush,
  output logic                 busy,
  output logic                 slice_done,
  output logic                 protocol_error
);

  localparam int CW_W = VAL_W + SIZE_W;
  localparam int LV_W = CW_W + 1;
  localparam logic [BLK_W-1:0] CNT_ONE  = {{(BLK_W-1){1'b0}}, 1'b1};
  localparam logic [BLK_W-1:0] CNT_ZERO = {BLK_W{1'b0}};

  logic             rdy_en_q;
  logic             dc_full_s,  dc_empty_s;
  logic             run_full_s, run_empty_s;
  logic             lvl_full_s, lvl_empty_s;
  logic [CW_W-1:0]  dc_rdata_s;
  logic [CW_W-1:0]  run_rdata_s;
  logic [LV_W-1:0]  lvl_rdata_s;
  logic             lvl_last_s;

  sched_state_e     state_q, state_d;
  logic [BLK_W-1:0] dc_cnt_q, dc_cnt_d;
  logic             pop_dc_s, pop_run_s, pop_lvl_s;
  logic             flush_d, done_d, err_d, busy_d, en_d;
  logic [SB_W-1:0]  val_d, size_d;

  logic             sb_enable_q, sb_flush_q, busy_q, slice_done_q, protocol_error_q;
  logic [SB_W-1:0]  sb_val_q, sb_size_q;

  // Ready is held low until the first clock after reset release, then tracks space.
  assign req.dc_ready  = rdy_en_q && !dc_full_s;
  assign req.run_ready = rdy_en_q && !run_full_s;
  assign req.lvl_ready = rdy_en_q && !lvl_full_s;

  // Level FIFO entries are {last, val, size}; the others are {val, size}.
  assign lvl_last_s = lvl_rdata_s[CW_W];

  codeword_fifo #(.WIDTH(CW_W), .DEPTH(FIFO_DEPTH)) u_dc_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (req.dc_valid && rdy_en_q),
    .wdata_i ({req.dc_val, req.dc_size}),
    .pop_i   (pop_dc_s),
    .rdata_o (dc_rdata_s),
    .full_o  (dc_full_s),
    .empty_o (dc_empty_s)
  );

  codeword_fifo #(.WIDTH(CW_W), .DEPTH(FIFO_DEPTH)) u_run_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (req.run_valid && rdy_en_q),
    .wdata_i ({req.run_val, req.run_size}),
    .pop_i   (pop_run_s),
    .rdata_o (run_rdata_s),
    .full_o  (run_full_s),
    .empty_o (run_empty_s)
  );

  codeword_fifo #(.WIDTH(LV_W), .DEPTH(FIFO_DEPTH)) u_lvl_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (req.lvl_valid && rdy_en_q),
    .wdata_i ({req.lvl_last, req.lvl_val, req.lvl_size}),
    .pop_i   (pop_lvl_s),
    .rdata_o (lvl_rdata_s),
    .full_o  (lvl_full_s),
    .empty_o (lvl_empty_s)
  );

  // Next-state logic: picks the single FIFO to pop this cycle from the state.
  always_comb begin
    state_d   = state_q;
    dc_cnt_d  = dc_cnt_q;
    pop_dc_s  = 1'b0;
    pop_run_s = 1'b0;
    pop_lvl_s = 1'b0;
    flush_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = slice_start && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (slice_start) begin
          dc_cnt_d = block_num;
          state_d  = (block_num == CNT_ZERO) ? AC_RUN : DC;
        end else begin
          state_d = IDLE;
        end
      end
      DC: begin
        if (!dc_empty_s) begin
          pop_dc_s = 1'b1;
          dc_cnt_d = dc_cnt_q - CNT_ONE;
          state_d  = (dc_cnt_q == CNT_ONE) ? AC_RUN : DC;
        end else begin
          state_d = DC;
        end
      end
      AC_RUN: begin
        if (!run_empty_s) begin
          pop_run_s = 1'b1;
          state_d   = AC_LVL;
        end else begin
          state_d = AC_RUN;
        end
      end
      AC_LVL: begin
        if (!lvl_empty_s) begin
          pop_lvl_s = 1'b1;
          state_d   = lvl_last_s ? FLUSH : AC_RUN;
        end else begin
          state_d = AC_LVL;
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output mux: the popped entry, zero-extended, or all-zero when nothing pops.
  always_comb begin
    en_d   = 1'b0;
    val_d  = {SB_W{1'b0}};
    size_d = {SB_W{1'b0}};
    if (pop_dc_s) begin
      en_d   = 1'b1;
      val_d  = {{(SB_W-VAL_W){1'b0}}, dc_rdata_s[CW_W-1:SIZE_W]};
      size_d = {{(SB_W-SIZE_W){1'b0}}, dc_rdata_s[SIZE_W-1:0]};
    end else if (pop_run_s) begin
      en_d   = 1'b1;
      val_d  = {{(SB_W-VAL_W){1'b0}}, run_rdata_s[CW_W-1:SIZE_W]};
      size_d = {{(SB_W-SIZE_W){1'b0}}, run_rdata_s[SIZE_W-1:0]};
    end else if (pop_lvl_s) begin
      en_d   = 1'b1;
      val_d  = {{(SB_W-VAL_W){1'b0}}, lvl_rdata_s[CW_W-1:SIZE_W]};
      size_d = {{(SB_W-SIZE_W){1'b0}}, lvl_rdata_s[SIZE_W-1:0]};
    end else begin
      en_d   = 1'b0;
      val_d  = {SB_W{1'b0}};
      size_d = {SB_W{1'b0}};
    end
  end

  // State, counter and registered outputs; reset clears all of them at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en_q         <= 1'b0;
      state_q          <= IDLE;
      dc_cnt_q         <= CNT_ZERO;
      sb_enable_q      <= 1'b0;
      sb_val_q         <= {SB_W{1'b0}};
      sb_size_q        <= {SB_W{1'b0}};
      sb_flush_q       <= 1'b0;
      busy_q           <= 1'b0;
      slice_done_q     <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      rdy_en_q         <= 1'b1;
      state_q          <= state_d;
      dc_cnt_q         <= dc_cnt_d;
      sb_enable_q      <= en_d;
      sb_val_q         <= val_d;
      sb_size_q        <= size_d;
      sb_flush_q       <= flush_d;
      busy_q           <= busy_d;
      slice_done_q     <= done_d;
      protocol_error_q <= err_d;
    end
  end

  assign sb_enable      = sb_enable_q;
  assign sb_val         = sb_val_q;
  assign sb_size_of_bit = sb_size_q;
  assign sb_flush       = sb_flush_q;
  assign busy           = busy_q;
  assign slice_done     = slice_done_q;
  assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_bitstream_scheduler.sv
// Self-checking bench for bitstream_scheduler: a slice-order reference model
// (queues of accepted codewords consumed in DC / run / level / flush / done
// order) checked every cycle, plus directed scenarios with literal expectations.
module tb_bitstream_scheduler;
  import prores_sched_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        slice_start;
  logic [31:0] block_num;
  logic        sb_enable, sb_flush, busy, slice_done, protocol_error;
  logic [63:0] sb_val, sb_size_of_bit;

  bitstream_scheduler_if ifc ();

  bitstream_scheduler dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .slice_start    (slice_start),
    .block_num      (block_num),
    .req            (ifc),
    .sb_enable      (sb_enable),
    .sb_val         (sb_val),
    .sb_size_of_bit (sb_size_of_bit),
    .sb_flush       (sb_flush),
    .busy           (busy),
    .slice_done     (slice_done),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  cw_t     dc_q[$];
  cw_t     run_q[$];
  lvl_cw_t lvl_q[$];
  cw_t     out_log[$];
  int      dc_left   = 0;
  bit      active    = 1'b0;
  bit      want_lvl  = 1'b0;
  bit      flush_due = 1'b0;
  bit      done_due  = 1'b0;
  bit      err_pend  = 1'b0;
  logic [2:0] rdy_prev = 3'b000;
  int      n_en = 0, n_flush = 0, n_done = 0, n_err = 0;

  task automatic model_clear();
    dc_q.delete(); run_q.delete(); lvl_q.delete();
    dc_left = 0; active = 1'b0; want_lvl = 1'b0;
    flush_due = 1'b0; done_due = 1'b0; err_pend = 1'b0;
  endtask

  // Compare process: record what the last edge accepted, then check outputs.
  always @(negedge clock) begin
    cw_t     e;
    lvl_cw_t l;
    bit      last_now;
    last_now = 1'b0;
    if (!reset_n) begin
      rdy_prev = 3'b000;
    end else begin
      if (ifc.dc_valid  && rdy_prev[0]) dc_q.push_back('{ifc.dc_val, ifc.dc_size});
      if (ifc.run_valid && rdy_prev[1]) run_q.push_back('{ifc.run_val, ifc.run_size});
      if (ifc.lvl_valid && rdy_prev[2]) lvl_q.push_back('{ifc.lvl_val, ifc.lvl_size, ifc.lvl_last});
      if (slice_start) begin
        if (active) err_pend = 1'b1;
        else begin
          active = 1'b1; dc_left = int'(block_num); want_lvl = 1'b0;
        end
      end
      check("protocol_error", protocol_error, err_pend);
      if (protocol_error) n_err++;
      err_pend = 1'b0;

      if (sb_enable) begin
        n_en++;
        out_log.push_back('{sb_val[31:0], sb_size_of_bit[5:0]});
        if (!active || flush_due || done_due) begin
          check("unexpected_enable", sb_enable, 1'b0);
        end else if (dc_left > 0) begin
          check("dc_entry_available", dc_q.size() > 0, 1'b1);
          if (dc_q.size() > 0) begin
            e = dc_q.pop_front();
            check("dc_val", sb_val, {32'h0, e.val});
            check("dc_size", sb_size_of_bit, {58'h0, e.size});
          end
          dc_left--;
        end else if (!want_lvl) begin
          check("run_entry_available", run_q.size() > 0, 1'b1);
          if (run_q.size() > 0) begin
            e = run_q.pop_front();
            check("run_val", sb_val, {32'h0, e.val});
            check("run_size", sb_size_of_bit, {58'h0, e.size});
          end
          want_lvl = 1'b1;
        end else begin
          check("lvl_entry_available", lvl_q.size() > 0, 1'b1);
          if (lvl_q.size() > 0) begin
            l = lvl_q.pop_front();
            check("lvl_val", sb_val, {32'h0, l.val});
            check("lvl_size", sb_size_of_bit, {58'h0, l.size});
            last_now = l.last;
          end
          want_lvl = 1'b0;
        end
      end else begin
        check("idle_val", sb_val, 64'h0);
        check("idle_size", sb_size_of_bit, 64'h0);
      end

      check("sb_flush", sb_flush, flush_due);
      check("slice_done", slice_done, done_due);
      if (sb_flush) n_flush++;
      if (slice_done) n_done++;
      if (done_due) active = 1'b0;
      done_due  = flush_due;
      flush_due = last_now;
      check("busy", busy, active);
    end
    rdy_prev = {ifc.lvl_ready, ifc.run_ready, ifc.dc_ready};
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic ready_of(input int ch);
    case (ch)
      0:       return ifc.dc_ready;
      1:       return ifc.run_ready;
      default: return ifc.lvl_ready;
    endcase
  endfunction

  // Hold valid until the DUT takes the codeword; reports cycles spent waiting.
  task automatic push(input int ch, input logic [31:0] v, input logic [5:0] s,
                      input logic last, output int waited);
    int n;
    n = 0;
    case (ch)
      0:       begin ifc.dc_valid = 1'b1;  ifc.dc_val = v;  ifc.dc_size = s;  end
      1:       begin ifc.run_valid = 1'b1; ifc.run_val = v; ifc.run_size = s; end
      default: begin ifc.lvl_valid = 1'b1; ifc.lvl_val = v; ifc.lvl_size = s; ifc.lvl_last = last; end
    endcase
    while (ready_of(ch) !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("push_accepted_in_time", n < 200, 1'b1);
    tick();
    case (ch)
      0:       ifc.dc_valid = 1'b0;
      1:       ifc.run_valid = 1'b0;
      default: begin ifc.lvl_valid = 1'b0; ifc.lvl_last = 1'b0; end
    endcase
    waited = n;
  endtask

  task automatic start_slice(input logic [31:0] b);
    slice_start = 1'b1;
    block_num   = b;
    tick();
    slice_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (active && n < 300) begin
      tick();
      n++;
    end
    check("slice_completes", active, 1'b0);
  endtask

  int w0, w1, w2, w5;
  int b, e0, f0, d0, r0;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; slice_start = 1'b0; block_num = 32'h0;
    ifc.dc_valid = 1'b0;  ifc.dc_val = 32'h0;  ifc.dc_size = 6'h0;
    ifc.run_valid = 1'b0; ifc.run_val = 32'h0; ifc.run_size = 6'h0;
    ifc.lvl_valid = 1'b0; ifc.lvl_val = 32'h0; ifc.lvl_size = 6'h0; ifc.lvl_last = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_outputs", {sb_enable, sb_flush, busy, slice_done, protocol_error}, 5'b0);
    check("rst_sb_val", sb_val, 64'h0);
    check("rst_ready", {ifc.dc_ready, ifc.run_ready, ifc.lvl_ready}, 3'b000);
    reset_n = 1'b1;
    tick();
    check("ready_after_reset", {ifc.dc_ready, ifc.run_ready, ifc.lvl_ready}, 3'b111);

    // T1: two DC, one run/level pair
    b = out_log.size(); f0 = n_flush; d0 = n_done;
    fork
      begin push(0, 32'h5, 6'd3, 1'b0, w0); push(0, 32'h1, 6'd1, 1'b0, w0); end
      push(1, 32'h2, 6'd2, 1'b0, w1);
      push(2, 32'h3, 6'd2, 1'b1, w2);
    join
    start_slice(32'd2);
    wait_done();
    check("t1_v0", {out_log[b+0].val, 26'h0, out_log[b+0].size}, {32'h5, 26'h0, 6'd3});
    check("t1_v1", {out_log[b+1].val, 26'h0, out_log[b+1].size}, {32'h1, 26'h0, 6'd1});
    check("t1_v2", {out_log[b+2].val, 26'h0, out_log[b+2].size}, {32'h2, 26'h0, 6'd2});
    check("t1_v3", {out_log[b+3].val, 26'h0, out_log[b+3].size}, {32'h3, 26'h0, 6'd2});
    check("t1_flush_count", n_flush - f0, 1);
    check("t1_done_count", n_done - d0, 1);

    // T2: block_num = 0, no DC pop
    b = out_log.size(); e0 = n_en;
    fork
      push(1, 32'h2, 6'd2, 1'b0, w1);
      push(2, 32'h3, 6'd2, 1'b1, w2);
    join
    start_slice(32'd0);
    check("t2_busy_after_start", busy, 1'b1);
    wait_done();
    check("t2_enable_count", n_en - e0, 2);
    check("t2_v0", {out_log[b+0].val, 26'h0, out_log[b+0].size}, {32'h2, 26'h0, 6'd2});
    check("t2_v1", {out_log[b+1].val, 26'h0, out_log[b+1].size}, {32'h3, 26'h0, 6'd2});

    // T3: DC backpressure, fifth push stalls until the first pop
    b = out_log.size();
    for (int i = 0; i < 4; i++) push(0, 32'h11 + 32'(i), 6'd5, 1'b0, w0);
    check("t3_dc_ready_full", ifc.dc_ready, 1'b0);
    fork
      push(0, 32'h15, 6'd5, 1'b0, w5);
      begin repeat (3) tick(); start_slice(32'd5); end
      push(1, 32'h21, 6'd6, 1'b0, w1);
      push(2, 32'h31, 6'd7, 1'b1, w2);
    join
    check("t3_fifth_stalled", w5 >= 4, 1'b1);
    wait_done();
    for (int i = 0; i < 5; i++)
      check("t3_dc_order", {32'h0, out_log[b+i].val}, 64'h11 + 64'(i));

    // T4: starvation in AC_LVL for 10 cycles
    b = out_log.size();
    push(1, 32'h0A, 6'd4, 1'b0, w1);
    start_slice(32'd0);
    repeat (3) tick();
    e0 = n_en;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_no_enable", sb_enable, 1'b0);
      check("t4_busy", busy, 1'b1);
    end
    check("t4_enable_count_stalled", n_en - e0, 0);
    push(2, 32'h0B, 6'd4, 1'b1, w2);
    wait_done();
    check("t4_lvl_emitted", {out_log[b+1].val, 26'h0, out_log[b+1].size}, {32'h0B, 26'h0, 6'd4});

    // T5: slice_start while busy in AC_RUN
    r0 = n_err; d0 = n_done;
    start_slice(32'd0);
    repeat (2) tick();
    start_slice(32'd7);
    tick();
    check("t5_error_pulses", n_err - r0, 1);
    check("t5_still_busy", busy, 1'b1);
    fork
      push(1, 32'h1C, 6'd5, 1'b0, w1);
      push(2, 32'h1D, 6'd5, 1'b1, w2);
    join
    wait_done();
    repeat (4) tick();
    check("t5_single_done", n_done - d0, 1);

    // T6: reset mid-DC with two run entries queued
    fork
      begin push(1, 32'h2A, 6'd3, 1'b0, w1); push(1, 32'h2B, 6'd3, 1'b0, w1); end
    join
    start_slice(32'd3);
    repeat (2) tick();
    check("t6_busy_before_reset", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check("t6_rst_outputs", {sb_enable, sb_flush, busy, slice_done, protocol_error}, 5'b0);
    check("t6_rst_val_size", {sb_val, sb_size_of_bit}, 128'h0);
    check("t6_rst_ready", {ifc.dc_ready, ifc.run_ready, ifc.lvl_ready}, 3'b000);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("t6_ready_after", {ifc.dc_ready, ifc.run_ready, ifc.lvl_ready}, 3'b111);
    check("t6_idle_after", busy, 1'b0);
    b = out_log.size();
    fork
      push(0, 32'hA, 6'd4, 1'b0, w0);
      push(1, 32'h0, 6'd0, 1'b0, w1);
      push(2, 32'h7, 6'd3, 1'b1, w2);
    join
    start_slice(32'd1);
    wait_done();
    check("t6_v0", {out_log[b+0].val, 26'h0, out_log[b+0].size}, {32'hA, 26'h0, 6'd4});
    check("t6_v1", {out_log[b+1].val, 26'h0, out_log[b+1].size}, {32'h0, 26'h0, 6'd0});
    check("t6_v2", {out_log[b+2].val, 26'h0, out_log[b+2].size}, {32'h7, 26'h0, 6'd3});

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
